// File: rtl/segment_fader_if.sv
// segment_fader_if: control/LED bundle between the pin wrapper (master) and segment_fader (slave)
// speed[2:0], direction, enable, fade_sel[1:0], bounce : controls driven by master
// led[CHANNELS-1:0], position, step_pulse            : outputs driven by slave
interface segment_fader_if #(
  parameter int CHANNELS = 8
);
  logic [2:0] speed;
  logic direction;
  logic enable;
  logic [1:0] fade_sel;
  logic bounce;
  logic [CHANNELS-1:0] led;
  logic [$clog2(CHANNELS)-1:0] position;
  logic step_pulse;
  modport master (output speed, direction, enable, fade_sel, bounce, input led, position, step_pulse);
  modport slave (input speed, direction, enable, fade_sel, bounce, output led, position, step_pulse);
endinterface

// File: rtl/segment_fader.sv
// segment_fader: moving head over CHANNELS PWM outputs with an exponentially fading tail
// clk     : sole clock, rising edge
// reset_n : synchronous active-low reset
// bus     : segment_fader_if.slave (speed, direction, enable, fade_sel, bounce in; led, position, step_pulse out)
// Optional bounce mode is built when SEGMENT_FADER_BOUNCE_EN is defined.
module segment_fader #(
  parameter int CHANNELS = 8,
  parameter int INTENSITY_W = 5,
  parameter int STEP_W = 24,
  parameter int FADE_W = 21,
  parameter int PWM_DIV_W = 6,
  parameter int ACTIVE_LOW_OUT = 1
) (
  input logic clk,
  input logic reset_n,
  segment_fader_if.slave bus
);
  localparam int PW = $clog2(CHANNELS);
  localparam int PWMW = INTENSITY_W + PWM_DIV_W;
  localparam logic [PW-1:0] LAST = PW'(CHANNELS - 1);
  logic [STEP_W-1:0] step_cnt, period;
  logic [FADE_W-1:0] fade_cnt, fade_mask;
  logic [PWMW-1:0] pwm_cnt;
  logic [INTENSITY_W-1:0] inten [CHANNELS];
  logic [INTENSITY_W-1:0] ps;
  logic [PW-1:0] pos, pos_wrap, pos_nxt;
  logic [CHANNELS-1:0] on, on_q;
  logic step, tick, dir, step_q;
  assign period = {~bus.speed, {(STEP_W - 3){1'b1}}};
  // >= so a mid-count speed increase steps immediately instead of wrapping
  assign step = bus.enable && step_cnt >= period;
  assign fade_mask = {FADE_W{1'b1}} >> bus.fade_sel;
  assign tick = (fade_cnt & fade_mask) == '0;
  assign ps = pwm_cnt[PWMW-1 -: INTENSITY_W];
  assign pos_wrap = dir ? (pos == LAST ? '0 : pos + 1'b1) : (pos == '0 ? LAST : pos - 1'b1);
`ifdef SEGMENT_FADER_BOUNCE_EN
  logic bdir, bdir_nxt, at_top, at_bot;
  assign dir = bus.bounce ? bdir : bus.direction;
  assign at_top = bus.bounce && bdir && pos == LAST;
  assign at_bot = bus.bounce && !bdir && pos == '0;
  assign pos_nxt = at_top ? LAST - 1'b1 : at_bot ? PW'(1) : pos_wrap;
  // outside bounce mode bdir shadows direction so entering bounce continues the same way
  assign bdir_nxt = !bus.bounce ? bus.direction : (step && at_top) ? 1'b0 : (step && at_bot) ? 1'b1 : bdir;
  always_ff @(posedge clk) begin
    if (!reset_n) bdir <= 1'b1;
    else bdir <= bdir_nxt;
  end
`else
  assign dir = bus.direction;
  assign pos_nxt = pos_wrap;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_cnt <= '0;
      fade_cnt <= '0;
      pwm_cnt <= '0;
      pos <= '0;
      on_q <= '0;
      step_q <= 1'b0;
    end else begin
      step_cnt <= step ? '0 : bus.enable ? step_cnt + 1'b1 : step_cnt;
      fade_cnt <= fade_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      pos <= step ? pos_nxt : pos;
      on_q <= on;
      step_q <= step;
    end
  end
  // head load beats a coincident fade tick
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++)
      inten[k] <= !reset_n ? '0 : pos == PW'(k) ? '1 : tick ? inten[k] >> 1 : inten[k];
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign on[i] = inten[i] != '0 && inten[i] >= ps;
  end
  assign bus.led = (ACTIVE_LOW_OUT != 0) ? ~on_q : on_q;
  assign bus.position = pos;
  assign bus.step_pulse = step_q;
endmodule

// File: tb/tb_segment_fader.sv
// tb_segment_fader: randomized check of segment_fader against a cycle-level arithmetic reference model
module tb_segment_fader;
  localparam int CH = 8;
  localparam int IW = 5;
  localparam int SW = 6;
  localparam int FW = 6;
  localparam int PD = 2;
  localparam int ALO = 1;
  localparam int MAXI = (1 << IW) - 1;
`ifdef SEGMENT_FADER_BOUNCE_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_scnt, m_fcnt, m_pwm, m_pos;
  int m_inten [CH];
  bit m_bdir, m_sp;
  bit [CH-1:0] m_on;
  segment_fader_if #(.CHANNELS(CH)) bus ();
  segment_fader #(
    .CHANNELS(CH), .INTENSITY_W(IW), .STEP_W(SW), .FADE_W(FW), .PWM_DIV_W(PD), .ACTIVE_LOW_OUT(ALO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int period_of(input int s);
    return (8 - s) * (1 << (SW - 3)) - 1;
  endfunction
  task automatic model();
    int ps;
    bit st, tk;
    if (!reset_n) begin
      m_scnt = 0; m_fcnt = 0; m_pwm = 0; m_pos = 0;
      for (int i = 0; i < CH; i++) m_inten[i] = 0;
      m_on = '0; m_sp = 0; m_bdir = 1;
      return;
    end
    st = bus.enable && m_scnt >= period_of(int'(bus.speed));
    tk = (m_fcnt % (1 << (FW - int'(bus.fade_sel)))) == 0;
    ps = m_pwm / (1 << PD);
    for (int i = 0; i < CH; i++) m_on[i] = m_inten[i] != 0 && m_inten[i] >= ps;
    for (int i = 0; i < CH; i++) m_inten[i] = (i == m_pos) ? MAXI : tk ? m_inten[i] / 2 : m_inten[i];
    if (st) begin
      if (BEN && bus.bounce) begin
        if (m_bdir) begin
          if (m_pos == CH - 1) begin m_pos = CH - 2; m_bdir = 0; end
          else m_pos++;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_bdir = 1; end
          else m_pos--;
        end
      end else m_pos = bus.direction ? (m_pos + 1) % CH : (m_pos + CH - 1) % CH;
    end
    if (BEN && !bus.bounce) m_bdir = bus.direction;
    m_scnt = st ? 0 : bus.enable ? m_scnt + 1 : m_scnt;
    m_fcnt = (m_fcnt + 1) % (1 << FW);
    m_pwm = (m_pwm + 1) % (1 << (IW + PD));
    m_sp = st;
  endtask
  task automatic cycle();
    logic [CH-1:0] e;
    @(posedge clk);
    model();
    #1;
    e = ALO != 0 ? ~m_on : m_on;
    chk("led", bus.led, e);
    chk("position", 32'(bus.position), m_pos);
    chk("step_pulse", bus.step_pulse, m_sp);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    bit hit;
    bus.speed = 3'd7; bus.direction = 1'b1; bus.enable = 1'b1; bus.fade_sel = 2'd3; bus.bounce = 1'b0;
    reset_n = 1'b0;
    run(3);
    chk("rst_led", bus.led, 8'hFF);
    chk("rst_pos", 32'(bus.position), 0);
    chk("rst_pulse", bus.step_pulse, 0);
    reset_n = 1'b1;
    run(2);
    chk("led0_on", bus.led[0], 0);
    run(70);
    bus.direction = 1'b0;
    run(30);
    bus.speed = 3'd0; bus.direction = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      hit = m_scnt == 20;
    end
    chk("late_wait", hit, 1);
    bus.speed = 3'd7;
    cycle();
    chk("late_step", bus.step_pulse, 1);
    bus.enable = 1'b0;
    run(50);
    bus.enable = 1'b1;
    bus.bounce = 1'b1;
    run(120);
    bus.bounce = 1'b0; bus.direction = 1'b1;
    run(60);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      hit = m_scnt >= period_of(int'(bus.speed));
      if (!hit) cycle();
    end
    chk("rst_step_wait", hit, 1);
    reset_n = 1'b0;
    cycle();
    chk("rst_step_pulse", bus.step_pulse, 0);
    chk("rst_step_pos", 32'(bus.position), 0);
    reset_n = 1'b1;
    run(5);
    for (int s = 0; s < 40; s++) begin
      bus.speed = 3'($urandom_range(3, 7));
      bus.direction = 1'($urandom_range(0, 1));
      bus.enable = $urandom_range(0, 3) != 0;
      bus.fade_sel = 2'($urandom_range(0, 3));
      bus.bounce = 1'($urandom_range(0, 1));
      reset_n = $urandom_range(0, 9) != 0;
      cycle();
      reset_n = 1'b1;
      for (int i = 0; i < int'($urandom_range(10, 150)); i++) begin
        if ($urandom_range(0, 30) == 0) bus.speed = 3'($urandom_range(0, 7));
        cycle();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
